// File: rtl/mc_control_fsm_pkg.sv
// Shared definitions for the multicycle MIPS controller: state encodings,
// opcode/funct constants, ALU operation codes and per-state control words.
package mc_control_fsm_pkg;

    localparam int OP_W       = 6;
    localparam int FUNCT_W    = 6;
    localparam int ALU_CTRL_W = 3;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EX     = 4'd6,
        S_R_WB     = 4'd7,
        S_BR       = 4'd8,
        S_JMP      = 4'd9,
        S_I_EX     = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    // How a state picks its ALU operation
    typedef enum logic [2:0] {
        AC_NONE, AC_ADD, AC_SUB, AC_RTYPE, AC_ITYPE
    } alu_class_t;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000, OP_LW   = 6'b100011,
                                OP_SW    = 6'b101011, OP_BEQ  = 6'b000100,
                                OP_J     = 6'b000010, OP_ADDI = 6'b001000,
                                OP_ANDI  = 6'b001100, OP_SLTI = 6'b001010;

    localparam logic [FUNCT_W-1:0] FN_ADD = 6'b100000, FN_SUB = 6'b100010,
                                   FN_AND = 6'b100100, FN_OR  = 6'b100101,
                                   FN_SLT = 6'b101010;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 3'b000, ALU_OR  = 3'b001,
                                      ALU_ADD = 3'b010, ALU_SUB = 3'b110,
                                      ALU_SLT = 3'b111;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       instr_done;
    } ctl_t;

    function automatic logic r_funct_ok(input logic [FUNCT_W-1:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT);
    endfunction

    // DECODE successor; S_FETCH here means the instruction is unsupported
    function automatic state_t decode_next(input logic [OP_W-1:0] op,
                                           input logic [FUNCT_W-1:0] fn);
        case (op)
            OP_RTYPE:                  return r_funct_ok(fn) ? S_R_EX : S_FETCH;
            OP_LW, OP_SW:              return S_MEM_ADDR;
            OP_BEQ:                    return S_BR;
            OP_J:                      return S_JMP;
            OP_ADDI, OP_ANDI, OP_SLTI: return S_I_EX;
            default:                   return S_FETCH;
        endcase
    endfunction

    function automatic ctl_t state_ctl(input state_t s);
        ctl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read = 1'b1; c.ir_write = 1'b1; c.pc_write = 1'b1;
                c.alu_src_b = 2'b01;
            end
            S_DECODE:   c.alu_src_b = 2'b11;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_MEM_RD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
            S_MEM_WB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_MEM_WR:   begin c.iord = 1'b1; c.mem_write = 1'b1; c.instr_done = 1'b1; end
            S_R_EX:     c.alu_src_a = 1'b1;
            S_R_WB:     begin c.reg_dst = 1'b1; c.reg_write = 1'b1; c.instr_done = 1'b1; end
            S_BR: begin
                c.alu_src_a = 1'b1; c.pc_src = 2'b01; c.pc_write_cond = 1'b1;
                c.instr_done = 1'b1;
            end
            S_JMP:      begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.instr_done = 1'b1; end
            S_I_EX:     begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
            S_I_WB:     begin c.reg_write = 1'b1; c.instr_done = 1'b1; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    function automatic alu_class_t alu_class(input state_t s);
        case (s)
            S_FETCH, S_DECODE, S_MEM_ADDR: return AC_ADD;
            S_BR:                          return AC_SUB;
            S_R_EX:                        return AC_RTYPE;
            S_I_EX:                        return AC_ITYPE;
            default:                       return AC_NONE;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_fsm_alu_op_decoder.sv
// Combinational ALU operation select from state class and the held IR fields.
module mc_control_fsm_alu_op_decoder
    import mc_control_fsm_pkg::*;
(
    input  alu_class_t              cls,
    input  logic [OP_W-1:0]         opcode,
    input  logic [FUNCT_W-1:0]      funct,
    output logic [ALU_CTRL_W-1:0]   alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_AND;
        case (cls)
            AC_ADD: alu_ctrl = ALU_ADD;
            AC_SUB: alu_ctrl = ALU_SUB;
            AC_RTYPE: begin
                case (funct)
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            AC_ITYPE: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_AND;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS main controller: Moore FSM with registered control word,
// pc_ld formed from the registered write enables and the live zero flag.
module mc_control_fsm
    import mc_control_fsm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OP_W-1:0]         opcode,
    input  logic [FUNCT_W-1:0]      funct,
    input  logic                    zero,
    output logic                    pc_ld,
    output logic                    iord,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic                    ir_write,
    output logic                    reg_dst,
    output logic                    mem_to_reg,
    output logic                    reg_write,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [1:0]              pc_src,
    output logic [ALU_CTRL_W-1:0]   alu_ctrl,
    output logic                    instr_done,
    output logic                    illegal_op
);

    state_t                  st, nxt;
    ctl_t                    ctl;
    alu_class_t              nxt_cls;
    logic [ALU_CTRL_W-1:0]   alu_q, alu_nxt;
    logic                    en;

    always_comb begin
        nxt = S_FETCH;
        case (st)
            S_FETCH:    nxt = S_DECODE;
            S_DECODE:   nxt = decode_next(opcode, funct);
            S_MEM_ADDR: nxt = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   nxt = S_MEM_WB;
            S_R_EX:     nxt = S_R_WB;
            S_I_EX:     nxt = S_I_WB;
            default:    nxt = S_FETCH;
        endcase
    end

    assign nxt_cls = alu_class(nxt);

    mc_control_fsm_alu_op_decoder u_alu_dec (
        .cls      (nxt_cls),
        .opcode   (opcode),
        .funct    (funct),
        .alu_ctrl (alu_nxt)
    );

    // Control word is computed for the state being entered, so it is valid from the cycle start
    always_ff @(posedge clk) begin
        if (rst) begin
            st    <= S_FETCH;
            ctl   <= state_ctl(S_FETCH);
            alu_q <= ALU_ADD;
        end else begin
            st    <= nxt;
            ctl   <= state_ctl(nxt);
            alu_q <= alu_nxt;
        end
    end

    // Reset forces outputs low immediately, so an aborted instruction cannot write
    assign en = ~rst & (st <= S_I_WB);

    assign pc_ld      = en & (ctl.pc_write | (ctl.pc_write_cond & zero));
    assign iord       = en & ctl.iord;
    assign mem_read   = en & ctl.mem_read;
    assign mem_write  = en & ctl.mem_write;
    assign ir_write   = en & ctl.ir_write;
    assign reg_dst    = en & ctl.reg_dst;
    assign mem_to_reg = en & ctl.mem_to_reg;
    assign reg_write  = en & ctl.reg_write;
    assign alu_src_a  = en & ctl.alu_src_a;
    assign alu_src_b  = en ? ctl.alu_src_b : 2'b00;
    assign pc_src     = en ? ctl.pc_src : 2'b00;
    assign alu_ctrl   = en ? alu_q : '0;
    assign instr_done = en & ctl.instr_done;
    assign illegal_op = en & (st == S_DECODE) & (decode_next(opcode, funct) == S_FETCH);

endmodule
